// File: rtl/reg_bus_master_pkg.sv
// Shared definitions for the slow-control register bus initiator:
// FSM state encoding and bus widths common with the TDC register decoder.
package reg_bus_master_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STROBE   = 2'd1,
    WAIT_ACK = 2'd2,
    RESP     = 2'd3
  } state_t;

endpackage

// File: rtl/reg_bus_master_sat_counter.sv
// Saturating up-counter used for the timeout and stray-ack error statistics.
// Holds at all-ones once reached; clear takes priority over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] out
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign out = cnt_reg;

endmodule

// File: rtl/reg_bus_master.sv
// Register bus initiator: one read/write at a time, single-cycle rd/wr strobe,
// bounded wait for ack, and a held response with read data and timeout status.
module reg_bus_master
  import reg_bus_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk_100_i,
  input  logic                 reset_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 rsp_write,
  output logic [ADDR_W-1:0]    addr,
  output logic [DATA_W-1:0]    data,
  input  logic [DATA_W-1:0]    rdata,
  output logic                 rd,
  output logic                 wr,
  input  logic                 ack,
  output logic [ERR_CNT_W-1:0] timeout_cnt,
  output logic [ERR_CNT_W-1:0] stray_ack_cnt
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t              state_reg, state_next;
  logic [15:0]         wait_cnt_reg, wait_cnt_next;
  logic                is_write_reg, is_write_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                rd_reg, rd_next;
  logic                wr_reg, wr_next;
  logic                cmd_ready_reg, cmd_ready_next;
  logic                rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic                rsp_timeout_reg, rsp_timeout_next;
  logic                rsp_write_reg, rsp_write_next;
  logic                timeout_inc;
  logic                stray_inc;

  always_ff @(posedge clk_100_i or negedge reset_i) begin
    if (!reset_i) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      is_write_reg    <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
      rd_reg          <= 1'b0;
      wr_reg          <= 1'b0;
      cmd_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_timeout_reg <= 1'b0;
      rsp_write_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      is_write_reg    <= is_write_next;
      addr_reg        <= addr_next;
      data_reg        <= data_next;
      rd_reg          <= rd_next;
      wr_reg          <= wr_next;
      cmd_ready_reg   <= cmd_ready_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_timeout_reg <= rsp_timeout_next;
      rsp_write_reg   <= rsp_write_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    is_write_next    = is_write_reg;
    addr_next        = addr_reg;
    data_next        = data_reg;
    rd_next          = 1'b0;
    wr_next          = 1'b0;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_timeout_next = rsp_timeout_reg;
    rsp_write_next   = rsp_write_reg;
    timeout_inc      = 1'b0;

    case (state_reg)
      IDLE: begin
        // cmd_ready is registered, so the first cycle after reset release never accepts
        if (cmd_valid && cmd_ready_reg) begin
          is_write_next = cmd_write;
          addr_next     = cmd_addr;
          data_next     = cmd_write ? cmd_wdata : '0;
          rd_next       = !cmd_write;
          wr_next       = cmd_write;
          state_next    = STROBE;
        end
      end
      STROBE: begin
        wait_cnt_next = '0;
        state_next    = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack) begin
          rsp_rdata_next   = is_write_reg ? '0 : rdata;
          rsp_timeout_next = 1'b0;
          rsp_write_next   = is_write_reg;
          state_next       = RESP;
        end else if (wait_cnt_reg == WAIT_LAST) begin
          rsp_rdata_next   = '0;
          rsp_timeout_next = 1'b1;
          rsp_write_next   = is_write_reg;
          timeout_inc      = 1'b1;
          state_next       = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    cmd_ready_next = (state_next == IDLE);
    rsp_valid_next = (state_next == RESP);
    stray_inc      = ack && (state_reg != WAIT_ACK);
  end

  sat_counter #(.W(ERR_CNT_W)) u_timeout_cnt (
    .clk   (clk_100_i),
    .rst_n (reset_i),
    .inc   (timeout_inc),
    .clear (1'b0),
    .out   (timeout_cnt)
  );

  sat_counter #(.W(ERR_CNT_W)) u_stray_ack_cnt (
    .clk   (clk_100_i),
    .rst_n (reset_i),
    .inc   (stray_inc),
    .clear (1'b0),
    .out   (stray_ack_cnt)
  );

  assign cmd_ready   = cmd_ready_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign rsp_write   = rsp_write_reg;
  assign addr        = addr_reg;
  assign data        = data_reg;
  assign rd          = rd_reg;
  assign wr          = wr_reg;

endmodule

// File: tb/tb_reg_bus_master.sv
// Directed plus randomized bench for reg_bus_master with a transaction-level
// responder model: ack offset decides ack-vs-timeout, latency and stray counts.
module tb_reg_bus_master;

  localparam int T  = 4;
  localparam int CW = 8;

  logic          clk_100_i = 1'b0;
  logic          reset_i   = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [15:0]   cmd_addr  = 16'h0;
  logic [31:0]   cmd_wdata = 32'h0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_timeout;
  logic          rsp_write;
  logic [15:0]   addr;
  logic [31:0]   data;
  logic [31:0]   rdata     = 32'h0;
  logic          rd;
  logic          wr;
  logic          ack       = 1'b0;
  logic [CW-1:0] timeout_cnt;
  logic [CW-1:0] stray_ack_cnt;

  int total = 0;
  int bad   = 0;
  int m_timeouts = 0;
  int m_strays   = 0;
  int txn_no     = 0;

  always #5 clk_100_i = ~clk_100_i;

  reg_bus_master #(.TIMEOUT_CYC(T), .ERR_CNT_W(CW)) dut (
    .clk_100_i     (clk_100_i),
    .reset_i       (reset_i),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_rdata     (rsp_rdata),
    .rsp_timeout   (rsp_timeout),
    .rsp_write     (rsp_write),
    .addr          (addr),
    .data          (data),
    .rdata         (rdata),
    .rd            (rd),
    .wr            (wr),
    .ack           (ack),
    .timeout_cnt   (timeout_cnt),
    .stray_ack_cnt (stray_ack_cnt)
  );

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rd_wr"}, {30'b0, rd, wr}, 32'h0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    check({tag, "_rsp_flags"}, {30'b0, rsp_timeout, rsp_write}, 32'h0);
    check({tag, "_addr"}, 32'(addr), 32'h0);
    check({tag, "_data"}, data, 32'h0);
    check({tag, "_timeout_cnt"}, 32'(timeout_cnt), 32'h0);
    check({tag, "_stray_cnt"}, 32'(stray_ack_cnt), 32'h0);
  endtask

  // k: ack offset in WAIT_ACK cycles (0 = first cycle after the strobe), -1 = during the
  // strobe, >= T never acked in time (k == T lands in the first RESP cycle), 99 = no ack.
  task automatic txn(input logic w, input logic [15:0] a, input logic [31:0] wd,
                     input logic [31:0] rv, input int k, input int rdy_dly);
    bit          accepted;
    int          exp_cyc;
    int          rsp_cyc;
    logic [31:0] exp_rdata;
    logic [31:0] exp_data;
    accepted  = (k >= 0) && (k < T);
    exp_cyc   = accepted ? k + 2 : T + 1;
    exp_rdata = (accepted && !w) ? rv : 32'h0;
    exp_data  = w ? wd : 32'h0;

    check("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd; rdata = rv;
    @(negedge clk_100_i);
    cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_wdata = $urandom;
    check("rd_strobe", 32'(rd), 32'(!w));
    check("wr_strobe", 32'(wr), 32'(w));
    check("bus_addr", 32'(addr), 32'(a));
    check("bus_data", data, exp_data);
    check("cmd_ready_busy", 32'(cmd_ready), 32'h0);
    ack = (k == -1);

    rsp_cyc = 0;
    for (int c = 1; c <= 40 && rsp_cyc == 0; c++) begin
      @(negedge clk_100_i);
      ack = (c - 1 == k);
      if (rsp_valid) rsp_cyc = c;
      else check("strobe_low", {30'b0, rd, wr}, 32'h0);
    end
    check("rsp_latency", 32'(rsp_cyc), 32'(exp_cyc));
    check("rsp_write", 32'(rsp_write), 32'(w));
    check("rsp_timeout", 32'(rsp_timeout), 32'(!accepted));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("addr_hold", 32'(addr), 32'(a));
    check("data_hold", data, exp_data);

    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk_100_i);
      ack = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'($urandom);
      check("hold_valid", 32'(rsp_valid), 32'h1);
      check("hold_rdata", rsp_rdata, exp_rdata);
      check("hold_flags", {30'b0, rsp_timeout, rsp_write}, {30'b0, !accepted, w});
      check("hold_cmd_ready", 32'(cmd_ready), 32'h0);
      check("hold_no_strobe", {30'b0, rd, wr}, 32'h0);
    end

    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk_100_i);
    rsp_ready = 1'b0; ack = 1'b0;
    if (!accepted) m_timeouts++;
    if (k == -1 || k == T) m_strays++;
    check("rsp_done", 32'(rsp_valid), 32'h0);
    check("no_accept_in_resp", {30'b0, rd, wr}, 32'h0);
    check("timeout_cnt", 32'(timeout_cnt), 32'(sat(m_timeouts)));
    check("stray_ack_cnt", 32'(stray_ack_cnt), 32'(sat(m_strays)));
    txn_no++;
    $display("txn %0d: %s addr=%04h k=%0d rdy_dly=%0d latency=%0d rdata=%08h timeout=%0d tcnt=%0d scnt=%0d",
             txn_no, w ? "WR" : "RD", a, k, rdy_dly, rsp_cyc, rsp_rdata, rsp_timeout,
             timeout_cnt, stray_ack_cnt);
  endtask

  initial begin
    repeat (3) @(negedge clk_100_i);
    check_idle_outputs("reset");
    check("reset_cmd_ready", 32'(cmd_ready), 32'h0);
    reset_i = 1'b1;
    check("release_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk_100_i);

    txn(1'b1, 16'h0010, 32'h1234ABCD, 32'h5A5A5A5A, 1, 0);
    txn(1'b0, 16'h0020, 32'h0, 32'hCAFEF00D, 0, 0);
    txn(1'b0, 16'h0030, 32'h0, 32'h11112222, 99, 0);
    txn(1'b0, 16'h0040, 32'h0, 32'h33334444, T - 1, 0);
    txn(1'b0, 16'h0050, 32'h0, 32'h55556666, T, 0);
    txn(1'b1, 16'h0060, 32'hDEADBEEF, 32'h0, 0, 10);
    txn(1'b0, 16'h0070, 32'h0, 32'h77778888, -1, 1);

    for (int i = 0; i < 40; i++) begin
      int r;
      int k;
      r = int'($urandom_range(0, 7));
      k = (r <= 5) ? r - 1 : 99;
      txn(1'($urandom), 16'($urandom), $urandom, $urandom, k, int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 300; i++) begin
      txn(1'b0, 16'($urandom), 32'h0, $urandom, 99, 0);
    end
    check("timeout_saturated", 32'(timeout_cnt), 32'd255);

    // Reset while the transaction sits in WAIT_ACK.
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h0055;
    @(negedge clk_100_i);
    cmd_valid = 1'b0;
    check("rst_rd_pulse", 32'(rd), 32'h1);
    @(negedge clk_100_i);
    #2 reset_i = 1'b0;
    #1;
    check_idle_outputs("midreset");
    check("midreset_cmd_ready", 32'(cmd_ready), 32'h0);
    m_timeouts = 0;
    m_strays   = 0;
    repeat (2) @(negedge clk_100_i);
    reset_i = 1'b1;
    check("rerelease_cmd_ready", 32'(cmd_ready), 32'h0);
    @(negedge clk_100_i);
    txn(1'b0, 16'h0099, 32'h0, 32'h0BADF00D, 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
